aes_key_sched_ctrl: RTL and testbench
=====================================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 Parameters: none; block SHALL support AES-128 only (10 rounds, 11 round keys).
REQ-002 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 key_valid  in  1  cipher key offered on key_in.
REQ-005 key_in  in  128  cipher key, word 0 in [127:96].
REQ-006 key_ready  out  1  controller accepts a key this cycle.
REQ-007 rk_req  in  1  round-key read request.
REQ-008 rk_idx  in  4  requested round index, 0..10.
REQ-009 rk_ack  out  1  one-cycle strobe: rk_data valid.
REQ-010 rk_data  out  128  requested round key.
REQ-011 keys_valid  out  1  all 11 round keys stored for current key.
REQ-012 busy  out  1  expansion in progress.
REQ-013 rk_err  out  1  one-cycle strobe: out-of-range index.

Function
REQ-014 FSM states SHALL be IDLE, EXPAND, READY; exactly one state active.
REQ-015 key_ready SHALL be 1 in IDLE and READY and 0 in EXPAND; key accepted on an edge where key_valid&&key_ready.
REQ-016 On accept: rk[0] <= key_in, round counter <= 1, keys_valid <= 0, state <= EXPAND.
REQ-017 In EXPAND, each cycle: rk[cnt] <= f(rk[cnt-1], RCON[cnt]), where f is the standard AES-128 step (RotWord, SubWord via four s_box instances, XOR Rcon into MSB byte, chained word XOR); cnt increments.
REQ-018 RCON[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-019 The edge that writes rk[10] SHALL move state to READY and set keys_valid=1; accept at edge N gives keys_valid=1 after edge N+10.
REQ-020 busy SHALL equal (state==EXPAND).
REQ-021 key_valid while in EXPAND SHALL be ignored (no abort, no restart); the requester holds it until key_ready.
REQ-022 Read: rk_req sampled at edge N with keys_valid=1 and rk_idx<=10 -> after edge N+1 the block SHALL assert rk_ack=1 for one cycle with rk_data=rk[rk_idx].
REQ-023 rk_req with keys_valid=1 and rk_idx>10 -> after edge N+1 the block SHALL assert rk_ack=1 and rk_err=1 for one cycle, with rk_data=0.
REQ-024 rk_req while keys_valid=0 SHALL be dropped: no rk_ack, no rk_err.
REQ-025 rk_req back-to-back every cycle SHALL be served at full rate, one ack per request, in order.
REQ-026 When rk_req and a key accept occur on the same edge in READY, the read SHALL return the old key set; later reads are dropped until the new keys_valid.
REQ-027 rk_data SHALL hold its last value when rk_ack=0.
REQ-028 Round-key storage SHALL be 11x128-bit registers; indices never wrap; cnt saturates at 10.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=IDLE, cnt=0, keys_valid=0, busy=0, rk_ack=0, rk_err=0, rk_data=0, key_ready=1 after release; key storage contents are don't-care.
REQ-030 Reset asserted mid-EXPAND SHALL abandon expansion; after release keys_valid stays 0 until a new full expansion completes.
REQ-031 Reset deassertion is synchronous to clk externally; no request is honoured on the release edge.

Verification
REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted -> keys_valid rises exactly 10 cycles later; read idx 1 -> a0fafe1788542cb123a339392a6c7605; idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; idx 0 -> key itself.
REQ-033 Read idx 10,9,...,0 on consecutive cycles -> 11 acks on consecutive cycles, in reverse order, all matching the golden model.
REQ-034 rk_req idx 11 and idx 15 in READY -> rk_ack=1, rk_err=1, rk_data=0; rk_req during EXPAND -> no ack.
REQ-035 Second key offered during EXPAND -> key_ready=0, ignored until READY, then accepted; keys_valid drops for 10 cycles; read on the accept edge returns old rk.
REQ-036 rst_n pulsed at EXPAND cycle 5 -> all outputs at reset values; key_ready=1 next cycle; new key expands correctly.
REQ-037 Random keys vs. software model, 1000 iterations, random read traffic -> zero mismatches, no ack without a request.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands one round key per cycle into an
// 11-entry register file and serves round-key reads through a two-stage pipeline.

module s_box (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    logic [7:0] pw;
    logic [7:0] inv;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), followed by the AES affine map.
    always_comb begin
        pw  = in_i;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// state  | meaning
// IDLE   | no key loaded since reset, accepting a key
// EXPAND | computing rk[1..10], one per cycle, keys not readable
// READY  | all 11 round keys valid, reads served, new key accepted
module aes_key_sched_ctrl (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         key_valid_i,
    input  logic [127:0] key_in_i,
    output logic         key_ready_o,
    input  logic         rk_req_i,
    input  logic [3:0]   rk_idx_i,
    output logic         rk_ack_o,
    output logic [127:0] rk_data_o,
    output logic         keys_valid_o,
    output logic         busy_o,
    output logic         rk_err_o
);
    localparam logic [3:0] LAST_RK = 4'd10;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         keys_valid_q, keys_valid_d;
    logic         key_acc, rk_we;
    logic [127:0] rk_q [0:10];

    logic [3:0]   prev_idx;
    logic [127:0] prev_rk, rk_next;
    logic [31:0]  w0, w1, w2, w3, rot_w, sub_w, tmp_w, n0, n1, n2, n3;
    logic [7:0]   rcon;

    logic         rd_hit, rd_bad;
    logic [3:0]   rd_sel;
    logic         s1_vld_q, s1_err_q;
    logic [127:0] s1_data_q;
    logic         rk_ack_q, rk_err_q;
    logic [127:0] rk_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        keys_valid_d = keys_valid_q;
        key_ready_o  = 1'b1;
        key_acc      = 1'b0;
        rk_we        = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (key_valid_i) begin
                    key_acc      = 1'b1;
                    state_d      = EXPAND;
                    cnt_d        = 4'd1;
                    keys_valid_d = 1'b0;
                end
            end
            EXPAND: begin
                key_ready_o = 1'b0;
                rk_we       = 1'b1;
                if (cnt_q == LAST_RK) begin
                    state_d      = READY;
                    keys_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign prev_idx         = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    assign prev_rk          = rk_q[prev_idx];
    assign {w0, w1, w2, w3} = prev_rk;
    assign rot_w            = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        s_box u_sbox (.in_i(rot_w[8*g +: 8]), .out_o(sub_w[8*g +: 8]));
    end

    assign tmp_w   = sub_w ^ {rcon, 24'h000000};
    assign n0      = w0 ^ tmp_w;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    // Key storage has no reset: its contents are meaningless until keys_valid.
    always_ff @(posedge clk_i) begin
        if (key_acc)    rk_q[0]     <= key_in_i;
        else if (rk_we) rk_q[cnt_q] <= rk_next;
    end

    assign rd_hit = rk_req_i && keys_valid_q;
    assign rd_bad = (rk_idx_i > LAST_RK);
    assign rd_sel = rd_bad ? 4'd0 : rk_idx_i;

    // Data is captured on the request edge so a key accepted on that same
    // edge cannot leak into the returned round key.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q  <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_data_q <= '0;
            rk_ack_q  <= 1'b0;
            rk_err_q  <= 1'b0;
            rk_data_q <= '0;
        end else begin
            s1_vld_q <= rd_hit;
            s1_err_q <= rd_hit && rd_bad;
            if (rd_hit) s1_data_q <= rd_bad ? '0 : rk_q[rd_sel];
            rk_ack_q <= s1_vld_q;
            rk_err_q <= s1_err_q;
            if (s1_vld_q) rk_data_q <= s1_data_q;
        end
    end

    assign rk_ack_o     = rk_ack_q;
    assign rk_err_o     = rk_err_q;
    assign rk_data_o    = rk_data_q;
    assign keys_valid_o = keys_valid_q;
    assign busy_o       = (state_q == EXPAND);
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: reads push expected responses,
// a negedge monitor pops and compares on every rk_ack.

module tb_aes_key_sched_ctrl;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_FIPS = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic         err;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready;
    logic         rk_req = 1'b0;
    logic [3:0]   rk_idx = '0;
    logic         rk_ack;
    logic [127:0] rk_data;
    logic         keys_valid;
    logic         busy;
    logic         rk_err;

    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    exp_t         sb_q[$];
    logic [127:0] gold [0:10];
    logic [127:0] last_exp = '0;

    aes_key_sched_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .key_valid_i(key_valid), .key_in_i(key_in),
        .key_ready_o(key_ready), .rk_req_i(rk_req), .rk_idx_i(rk_idx), .rk_ack_o(rk_ack),
        .rk_data_o(rk_data), .keys_valid_o(keys_valid), .busy_o(busy), .rk_err_o(rk_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] rc(input int r);
        case (r)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    task automatic gold_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
                t[31:24] = t[31:24] ^ rc(i / 4);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) gold[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Drives one request for the coming edge; served requests push their expected ack.
    task automatic rd(input logic [3:0] idx, input bit served, input logic err, input logic [127:0] data);
        exp_t e;
        rk_req = 1'b1;
        rk_idx = idx;
        if (served) begin
            e.err  = err;
            e.data = data;
            e.cyc  = cyc + 2;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic rd_gold(input logic [3:0] idx);
        if (idx > 4'd10) rd(idx, 1'b1, 1'b1, '0);
        else             rd(idx, 1'b1, 1'b0, gold[idx]);
    endtask

    task automatic idle(input int n);
        rk_req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_key(input logic [127:0] key, output int acc);
        int n;
        n = 0;
        key_valid = 1'b1;
        key_in    = key;
        while (!key_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("key_ready_wait", key_ready, 1);
        @(posedge clk); #1;
        acc       = cyc;
        key_valid = 1'b0;
    endtask

    task automatic wait_valid(input int acc);
        int n;
        n = 0;
        while (!keys_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("keys_valid_latency", cyc - acc, 10);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rk_err && !rk_ack) chk("err_without_ack", rk_err, 0);
        if (rk_ack) begin
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", rk_ack, 0);
            end else begin
                e = sb_q.pop_front();
                last_exp = e.data;
                chk("ack_cycle", cyc, e.cyc);
                chk("rk_data", rk_data, e.data);
                chk("rk_err", rk_err, e.err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [127:0] key_b, key_c, k;
        int nr;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_keys_valid", keys_valid, 0);
        chk("rst_rk_ack", rk_ack, 0);
        chk("rst_rk_err", rk_err, 0);
        chk("rst_rk_data", rk_data, 0);
        rst_n = 1'b1;
        chk("rst_key_ready", key_ready, 1);
        rd(4'd0, 1'b0, 1'b0, '0);
        idle(2);

        // FIPS-197 key
        gold_expand(KEY_FIPS);
        send_key(KEY_FIPS, acc);
        chk("expand_busy", busy, 1);
        chk("expand_key_ready", key_ready, 0);
        chk("expand_keys_valid", keys_valid, 0);
        rd(4'd2, 1'b0, 1'b0, '0);
        rk_req = 1'b0;
        wait_valid(acc);
        chk("ready_busy", busy, 0);
        chk("ready_key_ready", key_ready, 1);
        rd(4'd1, 1'b1, 1'b0, RK1_FIPS);
        rd(4'd10, 1'b1, 1'b0, RK10_FIPS);
        rd(4'd0, 1'b1, 1'b0, KEY_FIPS);
        rd(4'd11, 1'b1, 1'b1, '0);
        rd(4'd15, 1'b1, 1'b1, '0);
        idle(1);
        for (int i = 10; i >= 0; i--) rd_gold(4'(i));
        idle(4);
        chk("rk_data_hold", rk_data, last_exp);
        chk("rk_ack_idle", rk_ack, 0);

        // New key accepted on the same edge as a read; a third key waits out EXPAND
        key_b = 128'h000102030405060708090a0b0c0d0e0f;
        key_c = 128'h3243f6a8885a308d313198a2e0370734;
        key_valid = 1'b1;
        key_in    = key_b;
        rd_gold(4'd3);
        acc = cyc;
        rk_req = 1'b0;
        gold_expand(key_b);
        key_in = key_c;
        chk("second_key_blocked", key_ready, 0);
        nr = 0;
        while (!key_ready && nr < 30) begin
            if (nr == 2) rd(4'd5, 1'b0, 1'b0, '0);
            else begin @(posedge clk); #1; end
            rk_req = 1'b0;
            nr++;
        end
        chk("key_ready_low_cycles", cyc - acc, 10);
        chk("keys_valid_b", keys_valid, 1);
        rd_gold(4'd0);
        acc = cyc;
        key_valid = 1'b0;
        rk_req = 1'b0;
        gold_expand(key_c);
        chk("keys_valid_drop", keys_valid, 0);
        wait_valid(acc);
        for (int i = 0; i <= 10; i++) rd_gold(4'(i));
        idle(4);

        // Reset in the middle of expansion
        send_key(KEY_FIPS, acc);
        repeat (5) begin @(posedge clk); #1; end
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_keys_valid", keys_valid, 0);
        chk("mid_rst_rk_ack", rk_ack, 0);
        chk("mid_rst_rk_err", rk_err, 0);
        chk("mid_rst_rk_data", rk_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_key_ready", key_ready, 1);
        rd(4'd4, 1'b0, 1'b0, '0);
        idle(12);
        chk("mid_rst_no_valid", keys_valid, 0);
        gold_expand(KEY_FIPS);
        send_key(KEY_FIPS, acc);
        wait_valid(acc);
        for (int i = 0; i <= 10; i++) rd_gold(4'(i));
        idle(4);

        // Random keys with random read traffic
        for (int it = 0; it < 1000; it++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            gold_expand(k);
            send_key(k, acc);
            rd(4'($urandom_range(0, 15)), 1'b0, 1'b0, '0);
            rk_req = 1'b0;
            wait_valid(acc);
            nr = $urandom_range(1, 4);
            for (int j = 0; j < nr; j++) begin
                rd_gold(4'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) rk_req = 1'b0;
            end
            rk_req = 1'b0;
        end

        idle(5);
        chk("pending_reads", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
